// File: rtl/run_sched.sv
// Round-robin time-shared consecutive-ones run detector with per-channel saved run context.
// Optional per-channel sticky hit flags are compiled in with `define SCHED_STICKY_EN.
module run_sched #(
  parameter int CH_W    = 2,
  parameter int RUN_LEN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [(1<<CH_W)-1:0]    req,
  input  logic [(1<<CH_W)-1:0]    bit_in,
`ifdef SCHED_STICKY_EN
  input  logic [(1<<CH_W)-1:0]    clr_sticky,
  output logic [(1<<CH_W)-1:0]    sticky,
`endif
  output logic [(1<<CH_W)-1:0]    gnt,
  output logic                    hit,
  output logic [CH_W-1:0]         hit_ch
);

  localparam int NCH = 1 << CH_W;
  localparam logic [3:0] RUN_C = 4'(RUN_LEN);

  logic [CH_W-1:0] r_ptr;
  logic [3:0]      r_cnt [NCH];
  logic            r_hit;
  logic [CH_W-1:0] r_hit_ch;

  logic [NCH-1:0]  w_gnt;
  logic            w_gnt_vld;
  logic [CH_W-1:0] w_gnt_idx;
  logic [3:0]      w_cnt_sel;
  logic [3:0]      w_cnt_nxt;
  logic            w_hit_d;

  // Cyclic search from the pointer; the index wraps naturally at CH_W bits.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_gnt_vld && req[r_ptr + CH_W'(i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_ptr + CH_W'(i);
      end
    end
    w_gnt[w_gnt_idx] = w_gnt_vld;
  end

  always_comb begin
    w_cnt_sel = r_cnt[w_gnt_idx];
    w_cnt_nxt = '0;
    if (bit_in[w_gnt_idx]) begin
      w_cnt_nxt = (w_cnt_sel >= RUN_C) ? RUN_C : w_cnt_sel + 4'd1;
    end
    w_hit_d = w_gnt_vld & bit_in[w_gnt_idx] & (w_cnt_sel >= RUN_C - 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (w_gnt_vld) begin
      r_cnt[w_gnt_idx] <= w_cnt_nxt;
      r_ptr            <= w_gnt_idx + CH_W'(1);
    end
  end

  // hit_ch keeps the last hit's channel between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit    <= 1'b0;
      r_hit_ch <= '0;
    end else begin
      r_hit <= w_hit_d;
      if (w_hit_d) begin
        r_hit_ch <= w_gnt_idx;
      end
    end
  end

`ifdef SCHED_STICKY_EN
  logic [NCH-1:0] r_sticky;
  logic [NCH-1:0] w_sticky_set;

  // A hit always coincides with its channel's grant bit, so the grant masks the set.
  assign w_sticky_set = w_gnt & {NCH{w_hit_d}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= w_sticky_set | (r_sticky & ~clr_sticky);
    end
  end

  assign sticky = r_sticky;
`endif

  assign gnt    = w_gnt;
  assign hit    = r_hit;
  assign hit_ch = r_hit_ch;

endmodule
